if_id_skid_stage: RTL and testbench

Parametrised, flow-controlled IF→ID pipeline stage: a valid/ready stage register with a two-entry skid buffer, flush, and a saturating stall counter. It sits between instruction fetch and decode, replacing a free-running stage register. Downstream stalls back-pressure fetch without a combinational ready path, and branch redirects flush in one cycle.

---
 rtl/if_id_skid_stage.sv | 166 ++++++++++++++++
 tb/tb_if_id_skid_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// ---------------------------------------------------------------------------
// if_id_skid_stage
//
// Flow-controlled IF->ID pipeline register. A main entry drives the decode
// side; a second (skid) entry absorbs the beat that fetch presents in the
// cycle decode stalls. Because of the skid entry, in_ready is a pure decode
// of registered state and has no combinational path from out_ready or
// in_valid. A flush empties the stage in one cycle. A saturating counter
// records how many cycles decode back-pressured a valid beat.
//
// Parameters
//   ADDR_WIDTH  width of the PC field
//   INST_WIDTH  width of the instruction field
//   NOP_INST    instruction presented while the stage holds nothing valid
//   CNT_WIDTH   width of the stall counter
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   fetch presents a beat
//   in_pc      fetched PC
//   in_inst    fetched instruction
//   in_ready   stage accepts a beat this cycle
//   flush      discard held and incoming beats
//   out_valid  beat valid toward decode
//   out_pc     PC toward decode (0 when not valid)
//   out_inst   instruction toward decode (NOP_INST when not valid)
//   out_ready  decode takes the beat this cycle
//   stall_cnt  saturating count of back-pressured cycles
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_EMPTY  | nothing held; main payload parked at pc=0 / NOP_INST
// ST_ONE    | main entry valid, skid entry free
// ST_TWO    | main and skid valid; fetch is back-pressured
// ---------------------------------------------------------------------------
module if_id_skid_stage #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = '0,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [ADDR_WIDTH-1:0] in_pc,
   input  logic [INST_WIDTH-1:0] in_inst,
   output logic                  in_ready,
   input  logic                  flush,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [INST_WIDTH-1:0] out_inst,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] main_pc_q, main_pc_d;
   logic [INST_WIDTH-1:0] main_inst_q, main_inst_d;
   logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
   logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q;

   logic accept;
   logic deliver;
   logic stalled;

   // Valid bits are the occupancy state itself, so both handshake outputs
   // come straight from the state register.
   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = (state_q != ST_TWO);

   assign accept  = in_valid && in_ready;
   assign deliver = out_valid && out_ready;
   assign stalled = out_valid && !out_ready;

   // Main payload is forced to pc=0 / NOP_INST every time main goes
   // invalid, so the outputs need no masking mux.
   assign out_pc    = main_pc_q;
   assign out_inst  = main_inst_q;
   assign stall_cnt = stall_cnt_q;

   always_comb begin
      state_d     = state_q;
      main_pc_d   = main_pc_q;
      main_inst_d = main_inst_q;
      skid_pc_d   = skid_pc_q;
      skid_inst_d = skid_inst_q;

      if (flush) begin
         // Incoming beat is dropped even if accept is high.
         state_d     = ST_EMPTY;
         main_pc_d   = '0;
         main_inst_d = NOP_INST;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d     = ST_ONE;
                  main_pc_d   = in_pc;
                  main_inst_d = in_inst;
               end
            end
            ST_ONE: begin
               if (accept && deliver) begin
                  main_pc_d   = in_pc;
                  main_inst_d = in_inst;
               end else if (accept) begin
                  state_d     = ST_TWO;
                  skid_pc_d   = in_pc;
                  skid_inst_d = in_inst;
               end else if (deliver) begin
                  state_d     = ST_EMPTY;
                  main_pc_d   = '0;
                  main_inst_d = NOP_INST;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only the drain path exists.
               if (deliver) begin
                  state_d     = ST_ONE;
                  main_pc_d   = skid_pc_q;
                  main_inst_d = skid_inst_q;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               main_pc_d   = '0;
               main_inst_d = NOP_INST;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_pc_q   <= '0;
         main_inst_q <= NOP_INST;
         skid_pc_q   <= '0;
         skid_inst_q <= NOP_INST;
      end else begin
         state_q     <= state_d;
         main_pc_q   <= main_pc_d;
         main_inst_q <= main_inst_d;
         skid_pc_q   <= skid_pc_d;
         skid_inst_q <= skid_inst_d;
      end
   end

   // Flush deliberately leaves the counter alone; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (stalled && !(&stall_cnt_q)) begin
         stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

   localparam int          AW   = 32;
   localparam int          IW   = 32;
   localparam int          CW   = 4;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam int          CMAX = 15;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [AW-1:0] in_pc;
   logic [IW-1:0] in_inst;
   logic          in_ready;
   logic          flush;
   logic          out_valid;
   logic [AW-1:0] out_pc;
   logic [IW-1:0] out_inst;
   logic          out_ready;
   logic [CW-1:0] stall_cnt;

   int checks;
   int failures;

   if_id_skid_stage #(
      .ADDR_WIDTH (AW),
      .INST_WIDTH (IW),
      .NOP_INST   (NOP),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .out_ready (out_ready),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the stage is a 2-deep FIFO of {pc, inst}.
   logic [63:0] mq[$];
   int          mcnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle, advance the model, sample 1 time unit after the edge.
   task automatic cycle(input logic r, input logic iv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic fl, input logic ordy);
      bit m_ov, m_ir;
      rst       = r;
      in_valid  = iv;
      in_pc     = pc;
      in_inst   = inst;
      flush     = fl;
      out_ready = ordy;
      m_ov = (mq.size() > 0);
      m_ir = (mq.size() < 2);
      @(posedge clk);
      if (r) begin
         mq.delete();
         mcnt = 0;
      end else begin
         if (m_ov && !ordy && mcnt < CMAX) mcnt++;
         if (fl) mq.delete();
         else begin
            if (m_ov && ordy) void'(mq.pop_front());
            if (iv && m_ir) mq.push_back({pc, inst});
         end
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [63:0] head;
      head = (mq.size() > 0) ? mq[0] : {32'h0, NOP};
      check({tag, "_ov"},   64'(out_valid), 64'(mq.size() > 0));
      check({tag, "_ir"},   64'(in_ready),  64'(mq.size() < 2));
      check({tag, "_pc"},   64'(out_pc),    64'(head[63:32]));
      check({tag, "_inst"}, 64'(out_inst),  64'(head[31:0]));
      check({tag, "_cnt"},  64'(stall_cnt), 64'(mcnt));
   endtask

   typedef struct {
      logic        r, iv, fl, ordy;
      logic [31:0] pc, inst;
      logic        e_ov, e_ir;
      logic [31:0] e_pc, e_inst;
      logic [3:0]  e_cnt;
   } vec_t;

   function automatic vec_t mk(logic r, logic iv, logic [31:0] pc, logic [31:0] inst,
                               logic fl, logic ordy, logic e_ov, logic e_ir,
                               logic [31:0] e_pc, logic [31:0] e_inst, logic [3:0] e_cnt);
      vec_t v;
      v.r = r; v.iv = iv; v.pc = pc; v.inst = inst; v.fl = fl; v.ordy = ordy;
      v.e_ov = e_ov; v.e_ir = e_ir; v.e_pc = e_pc; v.e_inst = e_inst; v.e_cnt = e_cnt;
      return v;
   endfunction

   vec_t vecs[17];

   initial begin
      checks   = 0;
      failures = 0;
      mcnt     = 0;
      rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;

      //             rst iv  pc      inst    fl ordy  ov ir  e_pc    e_inst  cnt
      vecs[0]  = mk(1, 1, 32'hDEAD, 32'hBEEF, 0, 0,  0, 1, 32'h0,  NOP,    0); // reset w/ garbage
      vecs[1]  = mk(0, 1, 32'h0,  32'h11,  0, 1,  1, 1, 32'h0,  32'h11, 0); // streaming
      vecs[2]  = mk(0, 1, 32'h4,  32'h22,  0, 1,  1, 1, 32'h4,  32'h22, 0);
      vecs[3]  = mk(0, 1, 32'h8,  32'h33,  0, 1,  1, 1, 32'h8,  32'h33, 0);
      vecs[4]  = mk(0, 0, 32'h0,  32'h0,   0, 1,  0, 1, 32'h0,  NOP,    0);
      vecs[5]  = mk(0, 1, 32'h0,  32'h11,  0, 1,  1, 1, 32'h0,  32'h11, 0); // skid fill/drain
      vecs[6]  = mk(0, 1, 32'h4,  32'h22,  0, 0,  1, 0, 32'h0,  32'h11, 1);
      vecs[7]  = mk(0, 1, 32'h8,  32'h33,  0, 0,  1, 0, 32'h0,  32'h11, 2);
      vecs[8]  = mk(0, 1, 32'h8,  32'h33,  0, 0,  1, 0, 32'h0,  32'h11, 3);
      vecs[9]  = mk(0, 1, 32'h8,  32'h33,  0, 1,  1, 1, 32'h4,  32'h22, 3);
      vecs[10] = mk(0, 1, 32'h8,  32'h33,  0, 1,  1, 1, 32'h8,  32'h33, 3);
      vecs[11] = mk(0, 0, 32'h0,  32'h0,   0, 1,  0, 1, 32'h0,  NOP,    3);
      vecs[12] = mk(0, 1, 32'h10, 32'hA1,  0, 0,  1, 1, 32'h10, 32'hA1, 3); // flush in TWO
      vecs[13] = mk(0, 1, 32'h20, 32'hA2,  0, 0,  1, 0, 32'h10, 32'hA1, 4);
      vecs[14] = mk(0, 1, 32'h40, 32'hA4,  1, 0,  0, 1, 32'h0,  NOP,    5);
      vecs[15] = mk(0, 1, 32'h80, 32'hA8,  0, 1,  1, 1, 32'h80, 32'hA8, 5);
      vecs[16] = mk(0, 0, 32'h0,  32'h0,   0, 1,  0, 1, 32'h0,  NOP,    5);

      for (int i = 0; i < 17; i++) begin
         cycle(vecs[i].r, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].fl, vecs[i].ordy);
         check($sformatf("tbl%0d_ov", i),   64'(out_valid), 64'(vecs[i].e_ov));
         check($sformatf("tbl%0d_ir", i),   64'(in_ready),  64'(vecs[i].e_ir));
         check($sformatf("tbl%0d_pc", i),   64'(out_pc),    64'(vecs[i].e_pc));
         check($sformatf("tbl%0d_inst", i), 64'(out_inst),  64'(vecs[i].e_inst));
         check($sformatf("tbl%0d_cnt", i),  64'(stall_cnt), 64'(vecs[i].e_cnt));
      end

      // Saturation: hold a valid beat against a stalled decode for 20 cycles.
      cycle(0, 1, 32'h100, 32'h55, 0, 0);
      for (int i = 0; i < 20; i++) cycle(0, 0, 32'h0, 32'h0, 0, 0);
      check("sat_cnt", 64'(stall_cnt), 64'd15);
      check("sat_ov",  64'(out_valid), 64'd1);
      cycle(0, 0, 32'h0, 32'h0, 1, 0);
      check("sat_flush_cnt", 64'(stall_cnt), 64'd15);
      check("sat_flush_ov",  64'(out_valid), 64'd0);
      cycle(1, 0, 32'h0, 32'h0, 0, 0);
      check("sat_rst_cnt", 64'(stall_cnt), 64'd0);
      // Accept on the very first cycle after reset deasserts.
      cycle(0, 1, 32'h200, 32'h66, 0, 1);
      check("post_rst_pc", 64'(out_pc), 64'h200);

      // Accept+deliver every cycle: stays in ONE, never back-pressures.
      for (int i = 0; i < 10; i++) begin
         cycle(0, 1, 32'h300 + 32'(i * 4), 32'h70 + 32'(i), 0, 1);
         check("ad_ir",   64'(in_ready),  64'd1);
         check("ad_ov",   64'(out_valid), 64'd1);
         check("ad_pc",   64'(out_pc),    64'(32'h300 + 32'(i * 4)));
         check("ad_inst", 64'(out_inst),  64'(32'h70 + 32'(i)));
      end

      // Random traffic against the FIFO model.
      for (int i = 0; i < 3000; i++) begin
         logic r, iv, fl, ordy;
         r    = ($urandom_range(0, 199) == 0);
         fl   = ($urandom_range(0, 19) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 9) < 6);
         cycle(r, iv, $urandom, $urandom, fl, ordy);
         check_model("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
